// File: rtl/flit_inject_arbiter.sv
// flit_inject_arbiter
// Arbitrates two flit requesters onto a single network send port. Multi-flit
// packets hold the port until their tail flit is accepted, and each virtual
// channel has its own credit counter for the downstream input buffer.
//
// Ports:
//   CLK, RST               clock; asynchronous active-high reset
//   reqN_flit/valid/ready  requester N offer; ready is high in the cycle its flit is accepted
//   send_putFlit_flit_in   registered accepted flit (valid bit forced to 1)
//   EN_send_putFlit        send strobe, high in the cycle after an accept
//   send_getCredits        credit return {valid, vc}
//   EN_send_getCredits     credit poll enable, high every cycle out of reset
//   lock_owner             00 idle, 01 requester 0 holds port, 10 requester 1 holds port
//   credit_err             sticky flag set by a credit return to a full counter
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif

module flit_inject_arbiter #(
  parameter int FLIT_WIDTH = `FLIT_WIDTH,
  parameter int VC_BITS    = `VC_BITS,
  parameter int CREDITS    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [FLIT_WIDTH-1:0] req0_flit,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [FLIT_WIDTH-1:0] req1_flit,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  output logic [FLIT_WIDTH-1:0] send_putFlit_flit_in,
  output logic                  EN_send_putFlit,
  input  logic [VC_BITS:0]      send_getCredits,
  output logic                  EN_send_getCredits,
  output logic [1:0]            lock_owner,
  output logic                  credit_err
);

  localparam int NUM_VCS = 2 ** VC_BITS;
  localparam int CW      = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  // State encoding doubles as the lock_owner output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t state, stateNext;
  logic   prio, prioNext;   // 0: requester 0 holds round-robin priority
  logic [CW-1:0] credit [NUM_VCS];

  logic [VC_BITS-1:0]    vc0, vc1, acceptVc;
  logic                  has0, has1;
  logic                  grant0, grant1, accept;
  logic [FLIT_WIDTH-1:0] acceptFlit;
  logic [NUM_VCS-1:0]    takeVc, retVc;

  // The incoming valid bit is ignored; reqN_valid alone marks an offer.
  assign vc0  = req0_flit[FLIT_WIDTH-5 -: VC_BITS];
  assign vc1  = req1_flit[FLIT_WIDTH-5 -: VC_BITS];
  assign has0 = req0_valid && (credit[vc0] != '0);
  assign has1 = req1_valid && (credit[vc1] != '0);

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    stateNext = state;
    prioNext  = prio;
    if (!RST) begin
      unique case (state)
        IDLE: begin
          if (has0 && (!prio || !has1)) grant0 = 1'b1;
          else if (has1)                grant1 = 1'b1;
        end
        LOCK0:   grant0 = has0;
        LOCK1:   grant1 = has1;
        default: ;
      endcase
      if (grant0) begin
        if (req0_flit[FLIT_WIDTH-2]) begin
          stateNext = IDLE;
          prioNext  = ~prio;
        end else begin
          stateNext = LOCK0;
        end
      end else if (grant1) begin
        if (req1_flit[FLIT_WIDTH-2]) begin
          stateNext = IDLE;
          prioNext  = ~prio;
        end else begin
          stateNext = LOCK1;
        end
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acceptFlit = grant0 ? req0_flit : req1_flit;
  assign acceptVc   = grant0 ? vc0 : vc1;
  assign lock_owner = state;

  always_comb begin
    takeVc = '0;
    retVc  = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      takeVc[v] = accept && (acceptVc == v[VC_BITS-1:0]);
      retVc[v]  = EN_send_getCredits && send_getCredits[VC_BITS] &&
                  (send_getCredits[VC_BITS-1:0] == v[VC_BITS-1:0]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state                <= IDLE;
      prio                 <= 1'b0;
      send_putFlit_flit_in <= '0;
      EN_send_putFlit      <= 1'b0;
      EN_send_getCredits   <= 1'b0;
      credit_err           <= 1'b0;
      for (int unsigned v = 0; v < NUM_VCS; v++) credit[v] <= CREDIT_MAX;
    end else begin
      state              <= stateNext;
      prio               <= prioNext;
      EN_send_getCredits <= 1'b1;
      EN_send_putFlit    <= accept;
      if (accept) send_putFlit_flit_in <= {1'b1, acceptFlit[FLIT_WIDTH-2:0]};
      // Accept and return on the same VC cancel out; a return to a full
      // counter saturates and raises the sticky error instead.
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        unique case ({takeVc[v], retVc[v]})
          2'b10: credit[v] <= credit[v] - CW'(1);
          2'b01: begin
            if (credit[v] == CREDIT_MAX) credit_err <= 1'b1;
            else                         credit[v]  <= credit[v] + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flit_inject_arbiter.sv
`timescale 1ns/1ps
module tb_flit_inject_arbiter;

  localparam int FW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic [FW-1:0] req0_flit, req1_flit, send_putFlit_flit_in;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic          EN_send_putFlit, EN_send_getCredits, credit_err;
  logic [1:0]    send_getCredits, lock_owner;

  int compared   = 0;
  int mismatched = 0;
  logic [FW-1:0] expQ[$];
  logic [FW-1:0] monExp;

  always #5 CLK = ~CLK;

  flit_inject_arbiter #(.FLIT_WIDTH(FW), .VC_BITS(1), .CREDITS(8)) dut (
    .CLK(CLK), .RST(RST),
    .req0_flit(req0_flit), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_flit(req1_flit), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .send_putFlit_flit_in(send_putFlit_flit_in), .EN_send_putFlit(EN_send_putFlit),
    .send_getCredits(send_getCredits), .EN_send_getCredits(EN_send_getCredits),
    .lock_owner(lock_owner), .credit_err(credit_err)
  );

  // Input valid bit deliberately left 0; the DUT must still accept and set it.
  function automatic logic [FW-1:0] mk(input bit tail, input bit vc, input logic [15:0] pl);
    logic [FW-1:0] f;
    f = '0;
    f[FW-2] = tail;
    f[FW-5] = vc;
    f[15:0] = pl;
    return f;
  endfunction

  function automatic logic [FW-1:0] outOf(input logic [FW-1:0] f);
    logic [FW-1:0] o;
    o = f;
    o[FW-1] = 1'b1;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check ready/lock at the negedge, queue expected sends, take the edge.
  task automatic step(input logic e0, input logic e1, input logic [1:0] eLock, input string tag);
    @(negedge CLK);
    chk($sformatf("%s_ready0", tag), 32'(req0_ready), 32'(e0));
    chk($sformatf("%s_ready1", tag), 32'(req1_ready), 32'(e1));
    chk($sformatf("%s_lock", tag), 32'(lock_owner), 32'(eLock));
    if (e0) expQ.push_back(outOf(req0_flit));
    if (e1) expQ.push_back(outOf(req1_flit));
    @(posedge CLK);
    #1;
  endtask

  task automatic retCred(input bit vc, input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_getCredits = {1'b1, vc};
      step(1'b0, 1'b0, 2'b00, "ret");
    end
    send_getCredits = 2'b00;
  endtask

  // Monitor: every send strobe must match the oldest expected flit.
  initial begin
    forever begin
      @(negedge CLK);
      if (EN_send_putFlit === 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_put: got %h expected no send", send_putFlit_flit_in);
        end else begin
          monExp = expQ.pop_front();
          chk("put_flit", send_putFlit_flit_in, monExp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_flit = mk(1'b1, 1'b0, 16'h0001);
    req1_flit = mk(1'b1, 1'b0, 16'h0002);
    send_getCredits = 2'b00;
    #12;
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_lock", 32'(lock_owner), 0);
    chk("rst_en_put", 32'(EN_send_putFlit), 0);
    chk("rst_flit", send_putFlit_flit_in, 0);
    chk("rst_en_get", 32'(EN_send_getCredits), 0);
    chk("rst_cerr", 32'(credit_err), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("en_get_live", 32'(EN_send_getCredits), 1);

    // Both requesters, single-flit packets on VC0: grants alternate.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_flit = mk(1'b1, 1'b0, 16'hA000 + 16'(i));
      req1_flit = mk(1'b1, 1'b0, 16'hB000 + 16'(i));
      step(i % 2 == 0, i % 2 == 1, 2'b00, $sformatf("alt%0d", i));
    end
    req1_valid = 1'b0;
    // Four VC0 credits left: four more accepted, the fifth blocked.
    for (int i = 0; i < 4; i++) begin
      req0_flit = mk(1'b1, 1'b0, 16'hA010 + 16'(i));
      step(1'b1, 1'b0, 2'b00, "drain0");
    end
    req0_flit = mk(1'b1, 1'b0, 16'hA01F);
    step(1'b0, 1'b0, 2'b00, "vc0_empty");
    retCred(1'b0, 8);

    // Three-flit packet from requester 0 locks out requester 1.
    req1_valid = 1'b1;
    req1_flit = mk(1'b1, 1'b0, 16'hB100);
    req0_valid = 1'b1;
    req0_flit = mk(1'b0, 1'b0, 16'hA101);
    step(1'b1, 1'b0, 2'b00, "pkt_head");
    req0_flit = mk(1'b0, 1'b0, 16'hA102);
    step(1'b1, 1'b0, 2'b01, "pkt_body");
    req0_flit = mk(1'b1, 1'b0, 16'hA103);
    step(1'b1, 1'b0, 2'b01, "pkt_tail");
    req0_flit = mk(1'b1, 1'b0, 16'hA104);
    step(1'b0, 1'b1, 2'b00, "after_pkt");
    req1_valid = 1'b0;
    step(1'b1, 1'b0, 2'b00, "req0_again");
    retCred(1'b0, 5);

    // Exhaust VC1; a VC0 flit from the other requester still goes through.
    req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_flit = mk(1'b1, 1'b1, 16'hA200 + 16'(i));
      step(1'b1, 1'b0, 2'b00, "vc1_fill");
    end
    req0_flit = mk(1'b1, 1'b1, 16'hA2FF);
    req1_valid = 1'b1;
    req1_flit = mk(1'b1, 1'b0, 16'hB200);
    step(1'b0, 1'b1, 2'b00, "vc1_block");
    req1_valid = 1'b0;
    send_getCredits = 2'b11;
    step(1'b0, 1'b0, 2'b00, "vc1_ret");
    send_getCredits = 2'b00;
    step(1'b1, 1'b0, 2'b00, "vc1_resume");
    retCred(1'b1, 8);
    retCred(1'b0, 1);

    // Overflow on full VC0, then simultaneous accept and return at 5.
    chk("cerr_before", 32'(credit_err), 0);
    retCred(1'b0, 1);
    chk("cerr_set", 32'(credit_err), 1);
    retCred(1'b1, 0);
    repeat (3) step(1'b0, 1'b0, 2'b00, "idle");
    chk("cerr_sticky", 32'(credit_err), 1);
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_flit = mk(1'b1, 1'b0, 16'hA300 + 16'(i));
      step(1'b1, 1'b0, 2'b00, "to5");
    end
    req0_flit = mk(1'b1, 1'b0, 16'hA310);
    send_getCredits = 2'b10;
    step(1'b1, 1'b0, 2'b00, "acc_ret");
    send_getCredits = 2'b00;
    for (int i = 0; i < 5; i++) begin
      req0_flit = mk(1'b1, 1'b0, 16'hA320 + 16'(i));
      step(1'b1, 1'b0, 2'b00, "from5");
    end
    req0_flit = mk(1'b1, 1'b0, 16'hA3FF);
    step(1'b0, 1'b0, 2'b00, "at0");
    req0_valid = 1'b0;
    chk("cerr_still", 32'(credit_err), 1);

    // Reset in the middle of a requester 1 packet.
    req1_valid = 1'b1;
    req1_flit = mk(1'b0, 1'b1, 16'hB401);
    step(1'b0, 1'b1, 2'b00, "l1_head");
    req1_flit = mk(1'b0, 1'b1, 16'hB402);
    step(1'b0, 1'b1, 2'b10, "l1_body");
    req1_flit = mk(1'b0, 1'b1, 16'hB403);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_lock", 32'(lock_owner), 0);
    chk("mid_rst_en_put", 32'(EN_send_putFlit), 0);
    chk("mid_rst_flit", send_putFlit_flit_in, 0);
    chk("mid_rst_ready1", 32'(req1_ready), 0);
    chk("mid_rst_en_get", 32'(EN_send_getCredits), 0);
    chk("mid_rst_cerr", 32'(credit_err), 0);
    req0_valid = 1'b1;
    req0_flit = mk(1'b1, 1'b0, 16'hA500);
    req1_flit = mk(1'b1, 1'b0, 16'hB500);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(1'b1, 1'b0, 2'b00, "post_rst");
    req0_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req1_flit = mk(1'b1, 1'b1, 16'hB510 + 16'(i));
      step(1'b0, 1'b1, 2'b00, "vc1_full");
    end
    req1_flit = mk(1'b1, 1'b1, 16'hB5FF);
    step(1'b0, 1'b0, 2'b00, "vc1_9th");
    req1_valid = 1'b0;
    repeat (2) step(1'b0, 1'b0, 2'b00, "tail_idle");
    chk("queue_drained", 32'(expQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
